// File: rtl/mlp_node_array.sv
// Array of NODES fixed-point MAC neurons: acc_i = x.w_i + b_i, requantize by FRAC, optional ReLU.
// Latency: done 2 edges after the last accepted beat (2 after head when len=0); readout is combinational.
// No backpressure: beats are taken whenever data_valid is high in ACCUM. NODE_SAT_EN selects saturating narrowing.
module mlp_node_array #(
    parameter int NODES = 10,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 42
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                head_c2node,
    input  logic [9:0]          len_c2node,
    input  logic                relu_en,
    input  logic                data_valid,
    input  logic [DW-1:0]       x_data,
    input  logic [NODES*DW-1:0] w_data,
    input  logic [NODES*DW-1:0] b_data,
    input  logic [3:0]          data_select_c2node,
    output logic                done_flag_node2c,
    output logic                busy,
    output logic [DW-1:0]       node_data_out
);

    localparam int RW = ACC_W - FRAC;

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc      [NODES];
    logic [DW-1:0]     result   [NODES];
    logic [ACC_W-1:0]  prod_ext [NODES];
    logic [ACC_W-1:0]  biased   [NODES];
    logic [DW-1:0]     quant    [NODES];
    logic [9:0]        remaining;
    logic              relu_q;
    logic              take_beat;

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The beat that zeroes remaining leaves us in ACCUM for one more cycle,
    // so a loaded len of 0 and a finished vector share the same exit path.
    always_comb begin
        state_nxt = state;
        if (head_c2node) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (remaining == '0) state_nxt = BIAS;
                BIAS:    state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    for (genvar i = 0; i < NODES; i++) begin : g_lane
        logic signed [2*DW-1:0] prod;
        logic [RW-1:0]          r;
        logic [RW-1:0]          r_relu;

        assign prod        = $signed(x_data) * $signed(w_data[i*DW +: DW]);
        assign prod_ext[i] = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        assign biased[i]   = acc[i] + {{(ACC_W-DW-FRAC){b_data[i*DW+DW-1]}},
                                       b_data[i*DW +: DW], {FRAC{1'b0}}};
        // Dropping the low FRAC bits is an arithmetic shift rounding toward -inf.
        assign r      = biased[i][ACC_W-1:FRAC];
        assign r_relu = (relu_q && r[RW-1]) ? '0 : r;
`ifdef NODE_SAT_EN
        assign quant[i] = (r_relu[RW-1:DW-1] == {(RW-DW+1){r_relu[RW-1]}}) ? r_relu[DW-1:0] :
                          (r_relu[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
`else
        assign quant[i] = r_relu[DW-1:0];
`endif
    end

    assign take_beat = (state == ACCUM) && !head_c2node && data_valid && (remaining != '0);

    always_ff @(posedge clock) begin
        if (rst) begin
            remaining <= '0;
            relu_q    <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                acc[i]    <= '0;
                result[i] <= '0;
            end
        end else if (head_c2node) begin
            remaining <= len_c2node;
            relu_q    <= relu_en;
            for (int i = 0; i < NODES; i++) begin
                acc[i] <= '0;
            end
        end else if (take_beat) begin
            remaining <= remaining - 10'd1;
            for (int i = 0; i < NODES; i++) begin
                acc[i] <= acc[i] + prod_ext[i];
            end
        end else if (state == BIAS) begin
            for (int i = 0; i < NODES; i++) begin
                acc[i]    <= biased[i];
                result[i] <= quant[i];
            end
        end
    end

    assign done_flag_node2c = (state == DONE);
    assign busy             = (state == ACCUM) || (state == BIAS);

    always_comb begin
        node_data_out = '0;
        if (int'(data_select_c2node) < NODES) begin
            node_data_out = result[data_select_c2node];
        end
    end

endmodule

// File: tb/tb_mlp_node_array.sv
// Randomized and directed bench for mlp_node_array against an integer dot-product model.
module tb_mlp_node_array;
    localparam int NODES = 10;
    localparam int DW    = 16;
    localparam int FRAC  = 8;

    logic                clock = 1'b0;
    logic                rst;
    logic                head_c2node;
    logic [9:0]          len_c2node;
    logic                relu_en;
    logic                data_valid;
    logic [DW-1:0]       x_data;
    logic [NODES*DW-1:0] w_data;
    logic [NODES*DW-1:0] b_data;
    logic [3:0]          data_select_c2node;
    logic                done_flag_node2c;
    logic                busy;
    logic [DW-1:0]       node_data_out;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] xs [1024];
    logic [DW-1:0] ws [1024][NODES];
    logic [DW-1:0] bs [NODES];
    logic [DW-1:0] exp_res [NODES];

    always #5 clock = ~clock;

    mlp_node_array dut (
        .clock              (clock),
        .rst                (rst),
        .head_c2node        (head_c2node),
        .len_c2node         (len_c2node),
        .relu_en            (relu_en),
        .data_valid         (data_valid),
        .x_data             (x_data),
        .w_data             (w_data),
        .b_data             (b_data),
        .data_select_c2node (data_select_c2node),
        .done_flag_node2c   (done_flag_node2c),
        .busy               (busy),
        .node_data_out      (node_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] requant(input longint acc, input bit relu);
        longint r;
        r = acc >>> FRAC;
        if (relu && r < 0) r = 0;
`ifdef NODE_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[DW-1:0];
    endfunction

    task automatic compute_expected(input int len, input bit relu);
        for (int i = 0; i < NODES; i++) begin
            longint acc = 0;
            for (int k = 0; k < len; k++)
                acc += longint'($signed(xs[k])) * longint'($signed(ws[k][i]));
            acc += longint'($signed(bs[i])) * 256;
            exp_res[i] = requant(acc, relu);
        end
    endtask

    task automatic fill_random(input int len);
        for (int k = 0; k < len; k++) begin
            xs[k] = DW'($urandom);
            for (int i = 0; i < NODES; i++) ws[k][i] = DW'($urandom);
        end
        for (int i = 0; i < NODES; i++) bs[i] = DW'($urandom);
    endtask

    task automatic garbage_w();
        for (int i = 0; i < NODES; i++) w_data[i*DW +: DW] = DW'($urandom);
    endtask

    // Head cycle carries a random (discarded) data beat.
    task automatic start(input int len, input bit relu);
        @(negedge clock);
        head_c2node = 1'b1;
        len_c2node  = 10'(len);
        relu_en     = relu;
        data_valid  = 1'($urandom);
        x_data      = DW'($urandom);
        garbage_w();
        for (int i = 0; i < NODES; i++) b_data[i*DW +: DW] = bs[i];
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            head_c2node = 1'b0;
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    data_valid = 1'b0;
                    x_data     = DW'($urandom);
                    @(negedge clock);
                end
            end
            data_valid = 1'b1;
            x_data     = xs[k];
            for (int i = 0; i < NODES; i++) w_data[i*DW +: DW] = ws[k][i];
        end
    endtask

    // Extra valid beats after the last one must be ignored.
    task automatic wait_done();
        int edges = 0;
        int busy_cnt = 0;
        bit seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            head_c2node = 1'b0;
            if (done_flag_node2c) begin
                seen = 1;
                break;
            end
            edges++;
            if (busy) busy_cnt++;
            data_valid = 1'($urandom);
            x_data     = DW'($urandom);
            garbage_w();
        end
        data_valid = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_latency", 32'(edges), 32'd2);
        chk("busy_tail_cycles", 32'(busy_cnt), 32'd2);
        chk("busy_low_in_done", 32'(busy), 32'd0);
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < 16; s++) begin
            data_select_c2node = 4'(s);
            #1;
            chk($sformatf("%s_sel%0d", tag, s), 32'(node_data_out),
                (s < NODES) ? 32'(exp_res[s]) : 32'd0);
        end
    endtask

    task automatic run(input int len, input bit relu, input bit gaps, input string tag);
        compute_expected(len, relu);
        start(len, relu);
        feed(len, gaps);
        wait_done();
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] saved [NODES];
        logic [DW-1:0] sat_exp;

        rst = 1'b1; head_c2node = 1'b0; len_c2node = '0; relu_en = 1'b0;
        data_valid = 1'b0; x_data = '0; w_data = '0; b_data = '0; data_select_c2node = '0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        chk("reset_done", 32'(done_flag_node2c), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NODES; i++) exp_res[i] = '0;
        check_all("reset");

        // Basic dot product
        fill_random(3);
        for (int k = 0; k < 3; k++) begin xs[k] = 16'h0100; ws[k][0] = 16'h0200; end
        bs[0] = 16'h0080;
        run(3, 1'b1, 1'b0, "basic");
        data_select_c2node = 4'd0; #1;
        chk("basic_lane0_const", 32'(node_data_out), 32'h0680);

        // ReLU on a negative lane
        for (int k = 0; k < 3; k++) ws[k][1] = 16'hFF00;
        bs[1] = 16'h0000;
        run(3, 1'b1, 1'b0, "relu_on");
        data_select_c2node = 4'd1; #1;
        chk("relu_on_lane1", 32'(node_data_out), 32'h0000);
        run(3, 1'b0, 1'b0, "relu_off");
        data_select_c2node = 4'd1; #1;
        chk("relu_off_lane1", 32'(node_data_out), 32'hFD00);

        // Saturation vs wrap
        fill_random(4);
        for (int k = 0; k < 4; k++) begin xs[k] = 16'h7FFF; ws[k][0] = 16'h7FFF; end
        bs[0] = 16'h0000;
        run(4, 1'b0, 1'b0, "sat");
`ifdef NODE_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'hFC00;
`endif
        data_select_c2node = 4'd0; #1;
        chk("sat_lane0", 32'(node_data_out), 32'(sat_exp));

        // Gaps give the same result as back-to-back beats
        fill_random(8);
        run(8, 1'b0, 1'b0, "nogap");
        for (int i = 0; i < NODES; i++) saved[i] = exp_res[i];
        run(8, 1'b0, 1'b1, "gap");
        for (int i = 0; i < NODES; i++) begin
            data_select_c2node = 4'(i); #1;
            chk($sformatf("gap_vs_nogap_%0d", i), 32'(node_data_out), 32'(saved[i]));
        end

        // Restart after 2 of 5 beats; old results visible meanwhile
        fill_random(5);
        start(5, 1'b0);
        feed(2, 1'b0);
        data_select_c2node = 4'd3; #1;
        chk("hold_prev_results", 32'(node_data_out), 32'(saved[3]));
        xs[0] = 16'h0100; ws[0][0] = 16'h0100; bs[0] = 16'h0000;
        run(1, 1'b0, 1'b0, "restart");
        data_select_c2node = 4'd0; #1;
        chk("restart_lane0", 32'(node_data_out), 32'h0100);

        // Zero length
        fill_random(1);
        bs[0] = 16'h0300;
        run(0, 1'b1, 1'b0, "zero_len");
        data_select_c2node = 4'd0; #1;
        chk("zero_len_lane0", 32'(node_data_out), 32'h0300);

        // Random runs, plus one full-length vector
        for (int t = 0; t < 6; t++) begin
            int len = $urandom_range(1, 40);
            fill_random(len);
            run(len, 1'($urandom), 1'($urandom), $sformatf("rand%0d", t));
        end
        fill_random(784);
        run(784, 1'b0, 1'b1, "len784");

        // Reset mid-accumulation, with head in the same cycle (rst wins)
        fill_random(6);
        start(6, 1'b0);
        feed(3, 1'b0);
        @(negedge clock);
        rst = 1'b1; head_c2node = 1'b1; data_valid = 1'b1;
        @(negedge clock);
        rst = 1'b0; head_c2node = 1'b0; data_valid = 1'b0;
        chk("midrst_done", 32'(done_flag_node2c), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NODES; i++) exp_res[i] = '0;
        check_all("midrst");
        fill_random(1);
        run(1, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
